// File: rtl/alu_arb_pkg.sv
// Shared ALU function codes and requester ids for the shared-ALU arbiter.
package alu_arb_pkg;
  localparam logic [2:0] ADD  = 3'b000;
  localparam logic [2:0] SLL  = 3'b001;
  localparam logic [2:0] SLT  = 3'b010;
  localparam logic [2:0] SLTU = 3'b011;
  localparam logic [2:0] XOR  = 3'b100;
  localparam logic [2:0] SR   = 3'b101;
  localparam logic [2:0] OR   = 3'b110;
  localparam logic [2:0] AND  = 3'b111;

  typedef logic req_id_t;
  localparam req_id_t REQ_EX  = 1'b0;
  localparam req_id_t REQ_AGU = 1'b1;
endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two ALU requesters, the arbiter and the result consumer.
// Lock inputs exist only when ALU_ARB_LOCK_EN is defined.
interface alu_arbiter_if #(parameter int DATA_W = 32);
  import alu_arb_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_op1;
  logic [DATA_W-1:0] req0_op2;
  logic [2:0]        req0_funct3;
  logic              req0_shift_ctrl;
  logic              req0_sub_ctrl;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_op1;
  logic [DATA_W-1:0] req1_op2;
  logic [2:0]        req1_funct3;
  logic              req1_shift_ctrl;
  logic              req1_sub_ctrl;

`ifdef ALU_ARB_LOCK_EN
  logic              req0_lock;
  logic              req1_lock;
`endif

  logic              rsp_valid;
  logic              rsp_ready;
  req_id_t           rsp_id;
  logic [DATA_W-1:0] rsp_data;

  modport master (
`ifdef ALU_ARB_LOCK_EN
    output req0_lock, req1_lock,
`endif
    output req0_valid, req0_op1, req0_op2, req0_funct3, req0_shift_ctrl, req0_sub_ctrl,
    output req1_valid, req1_op1, req1_op2, req1_funct3, req1_shift_ctrl, req1_sub_ctrl,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data,
    output rsp_ready
  );

  modport slave (
`ifdef ALU_ARB_LOCK_EN
    input  req0_lock, req1_lock,
`endif
    input  req0_valid, req0_op1, req0_op2, req0_funct3, req0_shift_ctrl, req0_sub_ctrl,
    input  req1_valid, req1_op1, req1_op2, req1_funct3, req1_shift_ctrl, req1_sub_ctrl,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data,
    input  rsp_ready
  );
endinterface

// File: rtl/alu.sv
// Combinational integer ALU: add/sub, shifts, set-less-than, logic ops; wraps on overflow, no flags.
module alu
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic [2:0]        funct3,
  input  logic              shift_ctrl,
  input  logic              sub_ctrl,
  output logic [DATA_W-1:0] result
);
  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] shamt;
  assign shamt = op2[SH_W-1:0];

  always_comb begin
    result = '0;
    case (funct3)
      ADD:  result = sub_ctrl ? (op1 - op2) : (op1 + op2);
      SLL:  result = op1 << shamt;
      SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(op1) < $signed(op2))};
      SLTU: result = {{(DATA_W-1){1'b0}}, (op1 < op2)};
      XOR:  result = op1 ^ op2;
      SR:   result = shift_ctrl ? $unsigned($signed(op1) >>> shamt) : (op1 >> shamt);
      OR:   result = op1 | op2;
      AND:  result = op1 & op2;
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with priority pointer; with ALU_ARB_LOCK_EN the last winner
// can hold the grant while it keeps lock and valid high.
module rr_arb2
  import alu_arb_pkg::*;
#(
  parameter bit RESET_PTR = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
`ifdef ALU_ARB_LOCK_EN
  input  logic [1:0] lock,
`endif
  input  logic       advance,
  output logic       gnt_vld,
  output req_id_t    gnt_id
);
  logic    ptr;
  logic    locked;
  req_id_t last_id;
  logic    last_vld;

`ifdef ALU_ARB_LOCK_EN
  assign locked = last_vld && lock[last_id] && valid[last_id];
`else
  assign locked = 1'b0;
`endif

  always_comb begin
    gnt_vld = |valid;
    gnt_id  = ptr;
    if (locked)
      gnt_id = last_id;
    else if (valid == 2'b01)
      gnt_id = REQ_EX;
    else if (valid == 2'b10)
      gnt_id = REQ_AGU;
  end

  // A locked grant leaves the pointer where round-robin will resume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= RESET_PTR;
      last_id  <= REQ_EX;
      last_vld <= 1'b0;
    end else if (advance) begin
      if (!locked)
        ptr <= ~gnt_id;
      last_id  <= gnt_id;
      last_vld <= 1'b1;
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters; result registered into a single tagged response (1-cycle latency).
// Optional ALU_ARB_LOCK_EN adds per-requester lock to keep the grant across back-to-back ops.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int RESET_PTR = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);
  logic              accept;
  logic              fire;
  logic              gnt_vld;
  req_id_t           gnt_id;
  logic [DATA_W-1:0] alu_op1;
  logic [DATA_W-1:0] alu_op2;
  logic [2:0]        alu_funct3;
  logic              alu_shift;
  logic              alu_sub;
  logic [DATA_W-1:0] alu_res;

  logic              rsp_valid_q;
  req_id_t           rsp_id_q;
  logic [DATA_W-1:0] rsp_data_q;

  // The response slot can take a new result when empty or being drained this cycle.
  assign accept = !rsp_valid_q || bus.rsp_ready;
  assign fire   = rst_n && accept && gnt_vld;

  assign bus.req0_ready = fire && (gnt_id == REQ_EX);
  assign bus.req1_ready = fire && (gnt_id == REQ_AGU);

  rr_arb2 #(
    .RESET_PTR (1'(RESET_PTR))
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   ({bus.req1_valid, bus.req0_valid}),
`ifdef ALU_ARB_LOCK_EN
    .lock    ({bus.req1_lock, bus.req0_lock}),
`endif
    .advance (fire),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  always_comb begin
    alu_op1    = '0;
    alu_op2    = '0;
    alu_funct3 = '0;
    alu_shift  = 1'b0;
    alu_sub    = 1'b0;
    if (gnt_vld) begin
      if (gnt_id == REQ_EX) begin
        alu_op1    = bus.req0_op1;
        alu_op2    = bus.req0_op2;
        alu_funct3 = bus.req0_funct3;
        alu_shift  = bus.req0_shift_ctrl;
        alu_sub    = bus.req0_sub_ctrl;
      end else begin
        alu_op1    = bus.req1_op1;
        alu_op2    = bus.req1_op2;
        alu_funct3 = bus.req1_funct3;
        alu_shift  = bus.req1_shift_ctrl;
        alu_sub    = bus.req1_sub_ctrl;
      end
    end
  end

  alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op1        (alu_op1),
    .op2        (alu_op2),
    .funct3     (alu_funct3),
    .shift_ctrl (alu_shift),
    .sub_ctrl   (alu_sub),
    .result     (alu_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= REQ_EX;
      rsp_data_q  <= '0;
    end else if (fire) begin
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= gnt_id;
      rsp_data_q  <= alu_res;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: single op, contention, backpressure, ALU corners, mid-op reset, and lock (ALU_ARB_LOCK_EN).
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_W(32)) bus();

  alu_arbiter #(
    .DATA_W    (32),
    .RESET_PTR (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f, input logic sh, input logic sb);
    bus.req0_valid      = v;
    bus.req0_op1        = a;
    bus.req0_op2        = b;
    bus.req0_funct3     = f;
    bus.req0_shift_ctrl = sh;
    bus.req0_sub_ctrl   = sb;
  endtask

  task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f, input logic sh, input logic sb);
    bus.req1_valid      = v;
    bus.req1_op1        = a;
    bus.req1_op2        = b;
    bus.req1_funct3     = f;
    bus.req1_shift_ctrl = sh;
    bus.req1_sub_ctrl   = sb;
  endtask

  task automatic expect_rdy(input string tag, input logic r0, input logic r1);
    check(tag, 64'({bus.req0_ready, bus.req1_ready}), 64'({r0, r1}));
  endtask

  task automatic expect_rsp(input string tag, input logic v, input logic id, input logic [31:0] d);
    check({tag, "_vld"}, 64'(bus.rsp_valid), 64'(v));
    check({tag, "_id"},  64'(bus.rsp_id),    64'(id));
    check({tag, "_dat"}, 64'(bus.rsp_data),  64'(d));
  endtask

  // Requester-side protocol: payload must not change while valid is held without ready.
  logic        pend0 = 1'b0, pend1 = 1'b0;
  logic [63:0] hold0 = '0, hold1 = '0;
  always @(negedge clk) begin
    if (pend0 && bus.req0_valid) check("hold0", {bus.req0_op1, bus.req0_op2}, hold0);
    if (pend1 && bus.req1_valid) check("hold1", {bus.req1_op1, bus.req1_op2}, hold1);
    pend0 = bus.req0_valid && !bus.req0_ready;
    pend1 = bus.req1_valid && !bus.req1_ready;
    hold0 = {bus.req0_op1, bus.req0_op2};
    hold1 = {bus.req1_op1, bus.req1_op2};
  end

  logic [31:0] va  [8] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                           32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_F0F0, 32'h0000_0003};
  logic [31:0] vb  [8] = '{32'h1, 32'h4, 32'h4, 32'h1, 32'h1, 32'd31, 32'h0000_FF00, 32'h5};
  logic [2:0]  vf  [8] = '{ADD, SR, SR, SLT, SLTU, SLL, AND, ADD};
  logic        vsh [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        vsb [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [31:0] vex [8] = '{32'h0, 32'hF800_0000, 32'h0800_0000, 32'h1,
                           32'h0, 32'h8000_0000, 32'h0000_F000, 32'hFFFF_FFFE};

  initial begin
    rst_n = 1'b0;
    bus.rsp_ready = 1'b1;
`ifdef ALU_ARB_LOCK_EN
    bus.req0_lock = 1'b0;
    bus.req1_lock = 1'b0;
`endif
    drive0(1'b0, 32'h0, 32'h0, ADD, 1'b0, 1'b0);
    drive1(1'b0, 32'h0, 32'h0, ADD, 1'b0, 1'b0);
    repeat (2) tick();

    // Reset state; readies forced low even with a request pending.
    drive0(1'b1, 32'd5, 32'd3, ADD, 1'b0, 1'b0);
    #1;
    expect_rdy("rst_rdy", 1'b0, 1'b0);
    expect_rsp("rst", 1'b0, 1'b0, 32'h0);

    // Single request: same-cycle ready, result one cycle later, then drain.
    rst_n = 1'b1;
    #1;
    expect_rdy("single_rdy", 1'b1, 1'b0);
    tick();
    drive0(1'b0, 32'h0, 32'h0, ADD, 1'b0, 1'b0);
    expect_rsp("single", 1'b1, REQ_EX, 32'd8);
    tick();
    expect_rsp("drain", 1'b0, REQ_EX, 32'd8);

    // Contention from fresh reset: grants alternate 0,1,0 at full rate.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    drive0(1'b1, 32'd10, 32'd4, ADD, 1'b0, 1'b1);
    drive1(1'b1, 32'hF0, 32'hFF, XOR, 1'b0, 1'b0);
    #1;
    expect_rdy("cont_rdy0", 1'b1, 1'b0);
    tick();
    expect_rsp("cont0", 1'b1, REQ_EX, 32'd6);
    expect_rdy("cont_rdy1", 1'b0, 1'b1);
    tick();
    expect_rsp("cont1", 1'b1, REQ_AGU, 32'h0F);
    expect_rdy("cont_rdy2", 1'b1, 1'b0);
    tick();
    expect_rsp("cont2", 1'b1, REQ_EX, 32'd6);
    drive0(1'b0, 32'h0, 32'h0, ADD, 1'b0, 1'b0);
    drive1(1'b0, 32'h0, 32'h0, ADD, 1'b0, 1'b0);
    tick();
    check("cont_idle", 64'(bus.rsp_valid), 64'(0));

    // Backpressure: held response frozen, then next grant without a bubble (ptr=1).
    bus.rsp_ready = 1'b0;
    drive0(1'b1, 32'h10, 32'h02, ADD, 1'b0, 1'b0);
    #1;
    expect_rdy("bp_first_rdy", 1'b1, 1'b0);
    tick();
    expect_rsp("bp_first", 1'b1, REQ_EX, 32'h12);
    drive0(1'b1, 32'h20, 32'h01, ADD, 1'b0, 1'b1);
    drive1(1'b1, 32'h07, 32'h0C, OR, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      expect_rdy("bp_rdy", 1'b0, 1'b0);
      expect_rsp("bp_hold", 1'b1, REQ_EX, 32'h12);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    expect_rdy("bp_rel_rdy", 1'b0, 1'b1);
    tick();
    expect_rsp("bp_rel", 1'b1, REQ_AGU, 32'h0F);
    drive1(1'b0, 32'h0, 32'h0, ADD, 1'b0, 1'b0);
    #1;
    expect_rdy("bp_next_rdy", 1'b1, 1'b0);
    tick();
    expect_rsp("bp_next", 1'b1, REQ_EX, 32'h1F);
    drive0(1'b0, 32'h0, 32'h0, ADD, 1'b0, 1'b0);
    tick();
    check("bp_idle", 64'(bus.rsp_valid), 64'(0));

    // ALU corners through requester 1, one op per cycle.
    for (int i = 0; i < 8; i++) begin
      drive1(1'b1, va[i], vb[i], vf[i], vsh[i], vsb[i]);
      #1;
      expect_rdy("vec_rdy", 1'b0, 1'b1);
      tick();
      expect_rsp($sformatf("vec%0d", i), 1'b1, REQ_AGU, vex[i]);
    end
    drive1(1'b0, 32'h0, 32'h0, ADD, 1'b0, 1'b0);
    tick();

    // Reset while a response is stalled; after release RESET_PTR decides.
    bus.rsp_ready = 1'b0;
    drive0(1'b1, 32'd1, 32'd2, ADD, 1'b0, 1'b0);
    #1;
    tick();
    expect_rsp("mid_pre", 1'b1, REQ_EX, 32'd3);
    drive0(1'b1, 32'd9, 32'd1, ADD, 1'b0, 1'b0);
    drive1(1'b1, 32'd4, 32'd4, ADD, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", 64'(bus.rsp_valid), 64'(0));
    check("mid_rst_dat", 64'(bus.rsp_data), 64'(0));
    expect_rdy("mid_rst_rdy", 1'b0, 1'b0);
    bus.rsp_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    #1;
    expect_rdy("mid_ptr_rdy", 1'b1, 1'b0);
    tick();
    expect_rsp("mid_post0", 1'b1, REQ_EX, 32'd10);
    expect_rdy("mid_post_rdy", 1'b0, 1'b1);
    tick();
    expect_rsp("mid_post1", 1'b1, REQ_AGU, 32'd8);
    drive0(1'b0, 32'h0, 32'h0, ADD, 1'b0, 1'b0);
    drive1(1'b0, 32'h0, 32'h0, ADD, 1'b0, 1'b0);
    tick();

`ifdef ALU_ARB_LOCK_EN
    // Requester 1 was granted last and locks; ptr=0 would otherwise favour requester 0.
    drive0(1'b1, 32'd1, 32'd1, ADD, 1'b0, 1'b0);
    bus.req1_lock = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive1(1'b1, 32'(10 * (i + 1)), 32'd1, ADD, 1'b0, 1'b0);
      #1;
      expect_rdy("lock_rdy", 1'b0, 1'b1);
      tick();
      expect_rsp($sformatf("lock%0d", i), 1'b1, REQ_AGU, 32'(10 * (i + 1) + 1));
    end
    bus.req1_lock = 1'b0;
    #1;
    expect_rdy("unlock_rdy", 1'b1, 1'b0);
    tick();
    expect_rsp("unlock", 1'b1, REQ_EX, 32'd2);
    drive0(1'b0, 32'h0, 32'h0, ADD, 1'b0, 1'b0);
    drive1(1'b0, 32'h0, 32'h0, ADD, 1'b0, 1'b0);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
